// File: rtl/addsub_serial.sv
// addsub_serial
// Digit-serial adder/subtractor. An N = W*CC bit operation is fed one W-bit
// digit per cycle, least significant digit first, and produces one result
// digit per cycle. Digit 0 is computed in the same cycle that start is seen,
// so the result stream has no latency relative to the operand stream.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      begin an operation (accepted only in IDLE); digit 0 on a/b now
//   sub        mode, sampled with an accepted start: 0 = a+b, 1 = a-b
//   a, b       current operand digits, LSD first (unsigned)
//   c          current result digit (0 when valid is low)
//   valid      c holds a result digit this cycle
//   last       this cycle carries digit CC-1
//   busy       operation in progress (FSM in RUN)
//   cout       final carry of the last completed operation (sub: 1 = no borrow)
//   state_dbg  raw FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: there is no backpressure. Once start is accepted the caller must
// present one digit per cycle for CC consecutive cycles; valid marks each
// cycle whose c is meaningful and last marks the final one. A new start is
// accepted in the cycle right after last, so operations can run gaplessly.
module addsub_serial #(
    parameter int W  = 4,
    parameter int CC = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic         valid,
    output logic         last,
    output logic         busy,
    output logic         cout,
    output logic         state_dbg
);

    localparam int CW = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(CC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            carry_q;
    logic            mode_q;
    logic            cout_q;

    logic            accept;
    logic            mode_eff;
    logic            cin;
    logic [W-1:0]    b_eff;
    logic [W:0]      sum;

    always_comb begin
        accept   = 1'b0;
        valid    = 1'b0;
        mode_eff = 1'b0;
        cin      = 1'b0;
        b_eff    = '0;
        sum      = '0;
        c        = '0;
        last     = 1'b0;

        // Reset is folded in so nothing leaks onto the outputs while rst is
        // held, even if start is asserted at the same time.
        accept = (state == IDLE) && start && !rst;
        valid  = accept || ((state == RUN) && !rst);

        // In IDLE the mode and carry-in come straight from sub: subtraction
        // is a + ~b + 1, so the "+1" is the initial carry.
        mode_eff = (state == IDLE) ? sub : mode_q;
        cin      = (state == IDLE) ? sub : carry_q;
        b_eff    = b ^ {W{mode_eff}};
        sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};

        if (valid) begin
            c = sum[W-1:0];
        end
        // cnt is always 0 in IDLE, so this also covers CC == 1.
        last = valid && (cnt == LAST_IDX);
    end

    assign busy      = (state == RUN);
    assign cout      = cout_q;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else if (valid) begin
            carry_q <= sum[W];
            if (accept) begin
                mode_q <= sub;
            end
            if (last) begin
                cnt    <= '0;
                state  <= IDLE;
                cout_q <= sum[W];
            end else begin
                cnt    <= cnt + CW'(1);
                state  <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;

    logic clk;
    logic rst;

    // CC=2 instance
    logic       s2_start, s2_sub;
    logic [3:0] s2_a, s2_b, s2_c;
    logic       s2_valid, s2_last, s2_busy, s2_cout, s2_state;
    // CC=32 instance
    logic       s32_start, s32_sub;
    logic [3:0] s32_a, s32_b, s32_c;
    logic       s32_valid, s32_last, s32_busy, s32_cout, s32_state;
    // CC=1 instance
    logic       s1_start, s1_sub;
    logic [3:0] s1_a, s1_b, s1_c;
    logic       s1_valid, s1_last, s1_busy, s1_cout, s1_state;

    int n_checks;
    int n_fail;

    addsub_serial #(.W(4), .CC(2)) u_cc2 (
        .clk(clk), .rst(rst), .start(s2_start), .sub(s2_sub), .a(s2_a), .b(s2_b),
        .c(s2_c), .valid(s2_valid), .last(s2_last), .busy(s2_busy), .cout(s2_cout),
        .state_dbg(s2_state)
    );

    addsub_serial #(.W(4), .CC(32)) u_cc32 (
        .clk(clk), .rst(rst), .start(s32_start), .sub(s32_sub), .a(s32_a), .b(s32_b),
        .c(s32_c), .valid(s32_valid), .last(s32_last), .busy(s32_busy), .cout(s32_cout),
        .state_dbg(s32_state)
    );

    addsub_serial #(.W(4), .CC(1)) u_cc1 (
        .clk(clk), .rst(rst), .start(s1_start), .sub(s1_sub), .a(s1_a), .b(s1_b),
        .c(s1_c), .valid(s1_valid), .last(s1_last), .busy(s1_busy), .cout(s1_cout),
        .state_dbg(s1_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Checks every output of the CC=2 instance against expectations. Inputs
    // are driven on the falling edge and sampled 1 time unit later.
    task automatic test_reset();
        #1;
        n_checks++; if (s2_c !== 4'h0)    begin n_fail++; $display("FAIL reset_c2: got %h want 0", s2_c); end
        n_checks++; if (s2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b want 0", s2_valid); end
        n_checks++; if (s2_last !== 1'b0)  begin n_fail++; $display("FAIL reset_last2: got %b want 0", s2_last); end
        n_checks++; if (s2_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy2: got %b want 0", s2_busy); end
        n_checks++; if (s2_cout !== 1'b0)  begin n_fail++; $display("FAIL reset_cout2: got %b want 0", s2_cout); end
        n_checks++; if (s32_busy !== 1'b0 || s32_valid !== 1'b0) begin n_fail++; $display("FAIL reset_32: busy %b valid %b want 0 0", s32_busy, s32_valid); end
        n_checks++; if (s1_valid !== 1'b0 || s1_cout !== 1'b0) begin n_fail++; $display("FAIL reset_1: valid %b cout %b want 0 0", s1_valid, s1_cout); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (s2_valid !== 1'b0 || s2_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset2: valid %b busy %b want 0 0", s2_valid, s2_busy); end
    endtask

    // One CC=2 operation: two digits, then the registered cout/busy. When
    // glitch is set, start and sub are asserted during digit 1 and must be
    // ignored. prev_cout is the cout expected to hold throughout.
    task automatic op_cc2(input string nm, input logic s,
                          input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1,
                          input logic [3:0] e0, input logic [3:0] e1,
                          input logic prev_cout, input logic ecout, input logic glitch);
        @(negedge clk);
        s2_start = 1'b1; s2_sub = s; s2_a = a0; s2_b = b0;
        #1;
        n_checks++; if (s2_c !== e0)       begin n_fail++; $display("FAIL %s_d0_c: got %h want %h", nm, s2_c, e0); end
        n_checks++; if (s2_valid !== 1'b1) begin n_fail++; $display("FAIL %s_d0_valid: got %b want 1", nm, s2_valid); end
        n_checks++; if (s2_last !== 1'b0)  begin n_fail++; $display("FAIL %s_d0_last: got %b want 0", nm, s2_last); end
        n_checks++; if (s2_busy !== 1'b0)  begin n_fail++; $display("FAIL %s_d0_busy: got %b want 0", nm, s2_busy); end
        @(negedge clk);
        s2_start = glitch; s2_sub = glitch; s2_a = a1; s2_b = b1;
        #1;
        n_checks++; if (s2_c !== e1)       begin n_fail++; $display("FAIL %s_d1_c: got %h want %h", nm, s2_c, e1); end
        n_checks++; if (s2_valid !== 1'b1) begin n_fail++; $display("FAIL %s_d1_valid: got %b want 1", nm, s2_valid); end
        n_checks++; if (s2_last !== 1'b1)  begin n_fail++; $display("FAIL %s_d1_last: got %b want 1", nm, s2_last); end
        n_checks++; if (s2_busy !== 1'b1)  begin n_fail++; $display("FAIL %s_d1_busy: got %b want 1", nm, s2_busy); end
        n_checks++; if (s2_cout !== prev_cout) begin n_fail++; $display("FAIL %s_d1_cout_hold: got %b want %b", nm, s2_cout, prev_cout); end
        @(posedge clk);
        #1;
        s2_start = 1'b0; s2_sub = 1'b0; s2_a = 4'h0; s2_b = 4'h0;
        #1;
        n_checks++; if (s2_cout !== ecout) begin n_fail++; $display("FAIL %s_cout: got %b want %b", nm, s2_cout, ecout); end
        n_checks++; if (s2_busy !== 1'b0)  begin n_fail++; $display("FAIL %s_busy_after: got %b want 0", nm, s2_busy); end
        n_checks++; if (s2_valid !== 1'b0 || s2_c !== 4'h0) begin n_fail++; $display("FAIL %s_idle_out: valid %b c %h want 0 0", nm, s2_valid, s2_c); end
    endtask

    task automatic test_add();
        // 0x0F + 0x01 = 0x10, no carry out
        op_cc2("add", 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        // 0x10 - 0x01 = 0x0F, no borrow -> cout 1
        op_cc2("sub", 1'b1, 4'h0, 4'h1, 4'h1, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        // Same add as test_add, start+sub pulsed in digit 1; cout from the
        // previous subtraction (1) must hold until this add completes (0).
        op_cc2("ign", 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        // 0xFF + 0x01 wraps to 0x00 with carry out, then immediately
        // 0x00 - 0x01 wraps to 0xFF with borrow.
        op_cc2("wrap_add", 1'b0, 4'hF, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        op_cc2("wrap_sub", 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    endtask

    // CC=32: 0xFFFF...F + 1 wraps to zero with carry out.
    task automatic test_full32();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            s32_start = (i == 0); s32_sub = 1'b0; s32_a = 4'hF; s32_b = (i == 0) ? 4'h1 : 4'h0;
            #1;
            n_checks++; if (s32_c !== 4'h0 || s32_valid !== 1'b1) begin n_fail++; $display("FAIL full32_d%0d: c %h valid %b want 0 1", i, s32_c, s32_valid); end
            n_checks++; if (s32_last !== (i == 31)) begin n_fail++; $display("FAIL full32_last_d%0d: got %b want %b", i, s32_last, (i == 31)); end
            n_checks++; if (s32_busy !== (i != 0)) begin n_fail++; $display("FAIL full32_busy_d%0d: got %b want %b", i, s32_busy, (i != 0)); end
        end
        @(posedge clk);
        #1;
        s32_start = 1'b0; s32_a = 4'h0; s32_b = 4'h0;
        #1;
        n_checks++; if (s32_cout !== 1'b1 || s32_busy !== 1'b0) begin n_fail++; $display("FAIL full32_end: cout %b busy %b want 1 0", s32_cout, s32_busy); end
    endtask

    // CC=32: abort after digit 10 with an asynchronous reset, then a fresh 1+1.
    task automatic test_reset_mid_run();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            s32_start = (i == 0); s32_sub = 1'b0; s32_a = 4'hF; s32_b = 4'hF;
        end
        @(negedge clk);
        #1;
        n_checks++; if (s32_busy !== 1'b1 || s32_c !== 4'hF) begin n_fail++; $display("FAIL rst_pre: busy %b c %h want 1 f", s32_busy, s32_c); end
        rst = 1'b1;
        #1;
        n_checks++; if (s32_c !== 4'h0 || s32_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_out: c %h valid %b want 0 0", s32_c, s32_valid); end
        n_checks++; if (s32_busy !== 1'b0 || s32_last !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: busy %b last %b want 0 0", s32_busy, s32_last); end
        n_checks++; if (s32_cout !== 1'b0) begin n_fail++; $display("FAIL rst_async_cout: got %b want 0", s32_cout); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            s32_start = (i == 0); s32_a = (i == 0) ? 4'h1 : 4'h0; s32_b = (i == 0) ? 4'h1 : 4'h0;
            #1;
            n_checks++; if (s32_c !== ((i == 0) ? 4'h2 : 4'h0) || s32_valid !== 1'b1) begin n_fail++; $display("FAIL fresh_d%0d: c %h valid %b want %h 1", i, s32_c, s32_valid, ((i == 0) ? 4'h2 : 4'h0)); end
            n_checks++; if (s32_last !== (i == 31)) begin n_fail++; $display("FAIL fresh_last_d%0d: got %b want %b", i, s32_last, (i == 31)); end
        end
        @(posedge clk);
        #1;
        s32_start = 1'b0; s32_a = 4'h0; s32_b = 4'h0;
        #1;
        n_checks++; if (s32_cout !== 1'b0 || s32_busy !== 1'b0) begin n_fail++; $display("FAIL fresh_end: cout %b busy %b want 0 0", s32_cout, s32_busy); end
    endtask

    // CC=1: each start is a whole operation; three run gaplessly.
    task automatic test_cc1();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vs [3];
        logic [3:0] ec [3];
        logic       eco[3];
        // 9+8=0x11; 3-5=0xE (borrow); 2-1=1 (no borrow)
        va = '{4'h9, 4'h3, 4'h2}; vb = '{4'h8, 4'h5, 4'h1}; vs = '{1'b0, 1'b1, 1'b1};
        ec = '{4'h1, 4'hE, 4'h1}; eco = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s1_start = 1'b1; s1_sub = vs[i]; s1_a = va[i]; s1_b = vb[i];
            #1;
            n_checks++; if (s1_c !== ec[i]) begin n_fail++; $display("FAIL cc1_c_%0d: got %h want %h", i, s1_c, ec[i]); end
            n_checks++; if (s1_valid !== 1'b1 || s1_last !== 1'b1) begin n_fail++; $display("FAIL cc1_vl_%0d: valid %b last %b want 1 1", i, s1_valid, s1_last); end
            n_checks++; if (s1_busy !== 1'b0) begin n_fail++; $display("FAIL cc1_busy_%0d: got %b want 0", i, s1_busy); end
            if (i > 0) begin
                n_checks++; if (s1_cout !== eco[i-1]) begin n_fail++; $display("FAIL cc1_cout_hold_%0d: got %b want %b", i, s1_cout, eco[i-1]); end
            end
            @(posedge clk);
            #1;
            n_checks++; if (s1_cout !== eco[i] || s1_busy !== 1'b0) begin n_fail++; $display("FAIL cc1_cout_%0d: cout %b busy %b want %b 0", i, s1_cout, s1_busy, eco[i]); end
        end
        s1_start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        s2_start = 1'b0;  s2_sub = 1'b0;  s2_a = 4'h0;  s2_b = 4'h0;
        s32_start = 1'b0; s32_sub = 1'b0; s32_a = 4'h0; s32_b = 4'h0;
        s1_start = 1'b0;  s1_sub = 1'b0;  s1_a = 4'h0;  s1_b = 4'h0;

        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_back_to_back();
        test_full32();
        test_reset_mid_run();
        test_cc1();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter W, default 4, digit width in bits processed per cycle (W >= 1).
REQ-002 SHALL have parameter CC, default 32, number of cycles per operation (CC >= 1); operand width N = W*CC.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin operation; digit 0 is presented in the same cycle.
REQ-006 SHALL have port sub  input  1  mode sampled with start: 0 = a+b, 1 = a-b.
REQ-007 SHALL have port a  input  W  current operand-A digit, LSD first.
REQ-008 SHALL have port b  input  W  current operand-B digit, LSD first.
REQ-009 SHALL have port c  output  W  current result digit.
REQ-010 SHALL have port valid  output  1  c holds a result digit this cycle.
REQ-011 SHALL have port last  output  1  this cycle carries digit CC-1.
REQ-012 SHALL have port busy  output  1  operation in progress (state RUN).
REQ-013 SHALL have port cout  output  1  final carry of the most recent completed operation (sub: 1 = no borrow).

Function
REQ-014 SHALL implement FSM states IDLE and RUN, plus a digit counter of width clog2(CC) (min 1), a carry register, and a mode register.
REQ-015 IDLE with start=1: digit 0 SHALL be computed combinationally with carry-in = sub, b_eff = b XOR {W{sub}}; valid=1.
REQ-016 In RUN: each cycle SHALL compute one digit with carry-in = carry register and b_eff = b XOR {W{mode register}}; valid=1, busy=1.
REQ-017 c SHALL equal low W bits of a + b_eff + carry-in when valid=1, and 0 when valid=0.
REQ-018 Carry register SHALL capture bit W of that sum at the clock edge ending each valid digit.
REQ-019 Counter SHALL be 0 for digit 0, increment per valid digit, and return to 0 after digit CC-1.
REQ-020 last SHALL be 1 exactly when valid=1 and the digit index is CC-1; at that edge FSM SHALL go to IDLE and cout SHALL register the final carry.
REQ-021 IDLE to RUN SHALL occur on start=1 when CC > 1; with CC=1 start SHALL yield valid=last=1 in one cycle and remain IDLE.
REQ-022 start in RUN SHALL be ignored (no restart, no mode change, no counter reset); sub SHALL be ignored outside start-in-IDLE.
REQ-023 Back-to-back: start SHALL be accepted in the cycle after last, so gapless operations are possible.
REQ-024 Arithmetic SHALL wrap modulo 2^N; overflow is reported only via cout; a and b are unsigned digits.
REQ-025 cout SHALL hold its value until the next operation completes; it SHALL not change mid-operation.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, counter 0, carry 0, mode 0, cout 0, independent of clk.
REQ-027 During and after reset until start: c=0, valid=0, last=0, busy=0, cout=0.
REQ-028 Reset mid-operation SHALL abort it; partial digits SHALL not affect cout; next start SHALL begin a fresh digit 0.

Verification (W=4, CC=2 unless stated)
REQ-029 Add 0x0F+0x01: start,sub=0,a=F,b=1 -> c=0,valid=1; next a=0,b=0 -> c=1,last=1; then cout=0, busy=0.
REQ-030 Sub 0x10-0x01: start,sub=1,a=0,b=1 -> c=F; next a=1,b=0 -> c=0,last=1; then cout=1.
REQ-031 Wrap 0xFF+0x01: digits (F,1),(F,0) -> c=0,0; cout=1; and 0x00-0x01 -> c=F,F, cout=0.
REQ-032 start asserted with sub=1 during digit 1 of an add -> ignored; result and cout unchanged; busy drops after last.
REQ-033 rst pulsed mid-RUN (W=4,CC=32, after digit 10) -> outputs 0 asynchronously, busy=0; fresh 1+1 yields c=2 at digit 0, cout=0.
REQ-034 CC=1: start,a=9,b=8 -> c=1,valid=last=1 same cycle, busy stays 0, cout=1 next cycle; two gapless operations both correct.
